// File: rtl/bypass_result_tracker_pkg.sv
// Shared widths and the shadow-pipeline entry layout for the bypass result tracker.
package bypass_result_tracker_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int CNT_WIDTH  = 16;

  localparam logic [0:ADDR_WIDTH-1] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [0:ADDR_WIDTH-1] rd;
    logic                  is_load;
    logic [0:DATA_WIDTH-1] data;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '0;

  function automatic logic entry_match(input entry_t e, input logic [0:ADDR_WIDTH-1] addr);
    return e.valid && (e.rd == addr);
  endfunction

endpackage

// File: rtl/bypass_lookup.sv
// One forwarding port: finds the youngest in-flight writer of src_addr and selects its data,
// or requests a stall when that writer is a load still in EX.
module bypass_lookup
  import bypass_result_tracker_pkg::*;
(
  input  entry_t                ex_entry,
  input  entry_t                mem_entry,
  input  entry_t                wb_entry,
  input  logic [0:ADDR_WIDTH-1] src_addr,
  input  logic [0:DATA_WIDTH-1] ex_result,
  input  logic [0:DATA_WIDTH-1] mem_load_data,
  output logic                  hit,
  output logic [0:DATA_WIDTH-1] data,
  output logic                  stall_req
);

  always_comb begin
    hit       = 1'b0;
    data      = '0;
    stall_req = 1'b0;
    if (src_addr != REG_ZERO) begin
      // The youngest match decides alone; an unready EX load masks older copies.
      if (entry_match(ex_entry, src_addr)) begin
        if (ex_entry.is_load) begin
          stall_req = 1'b1;
        end else begin
          hit  = 1'b1;
          data = ex_result;
        end
      end else if (entry_match(mem_entry, src_addr)) begin
        hit  = 1'b1;
        data = mem_entry.is_load ? mem_load_data : mem_entry.data;
      end else if (entry_match(wb_entry, src_addr)) begin
        hit  = 1'b1;
        data = wb_entry.data;
      end
    end
  end

endmodule

// File: rtl/bypass_result_tracker.sv
// Producer-side operand forwarding: EX/MEM/WB shadow of in-flight register writes, two
// lookup ports for ID sources, load-use stall generation and a saturating stall counter.
module bypass_result_tracker
  import bypass_result_tracker_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_freeze,
  input  logic                  ex_flush,
  input  logic                  id_valid,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic [0:ADDR_WIDTH-1] id_rD_address,
  input  logic [0:ADDR_WIDTH-1] id_rA_address,
  input  logic [0:ADDR_WIDTH-1] id_rB_address,
  input  logic [0:DATA_WIDTH-1] ex_result,
  input  logic [0:DATA_WIDTH-1] mem_load_data,
  output logic                  fwd_rA_hit,
  output logic [0:DATA_WIDTH-1] fwd_rA_data,
  output logic                  fwd_rB_hit,
  output logic [0:DATA_WIDTH-1] fwd_rB_data,
  output logic                  load_use_stall,
  output logic [0:CNT_WIDTH-1]  stall_count
);

  entry_t ex_q, ex_d;
  entry_t mem_q, mem_d;
  entry_t wb_q, wb_d;
  logic [0:CNT_WIDTH-1] stall_count_q, stall_count_d;
  logic stall_a, stall_b;

  bypass_lookup u_lookup_a (
    .ex_entry      (ex_q),
    .mem_entry     (mem_q),
    .wb_entry      (wb_q),
    .src_addr      (id_rA_address),
    .ex_result     (ex_result),
    .mem_load_data (mem_load_data),
    .hit           (fwd_rA_hit),
    .data          (fwd_rA_data),
    .stall_req     (stall_a)
  );

  bypass_lookup u_lookup_b (
    .ex_entry      (ex_q),
    .mem_entry     (mem_q),
    .wb_entry      (wb_q),
    .src_addr      (id_rB_address),
    .ex_result     (ex_result),
    .mem_load_data (mem_load_data),
    .hit           (fwd_rB_hit),
    .data          (fwd_rB_data),
    .stall_req     (stall_b)
  );

  assign load_use_stall = stall_a | stall_b;
  assign stall_count    = stall_count_q;

  always_comb begin
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    stall_count_d = stall_count_q;
    if (!pipe_freeze) begin
      // A stalled or flushed ID slot enters EX as a bubble.
      ex_d         = ENTRY_EMPTY;
      ex_d.valid   = id_valid & id_wr_en & (id_rD_address != REG_ZERO)
                   & ~ex_flush & ~load_use_stall;
      ex_d.rd      = id_rD_address;
      ex_d.is_load = id_is_load;

      // Each result is captured on leaving the stage that produces it.
      mem_d = ex_q;
      if (!ex_q.is_load) mem_d.data = ex_result;
      wb_d = mem_q;
      if (mem_q.is_load) wb_d.data = mem_load_data;

      if (load_use_stall && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q          <= ENTRY_EMPTY;
      mem_q         <= ENTRY_EMPTY;
      wb_q          <= ENTRY_EMPTY;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule
